pong_game_ctrl: RTL and testbench



---
 rtl/pong_game_ctrl_pkg.sv | 28 ++
 rtl/pong_ball_step.sv | 51 +++++
 rtl/pong_game_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_game_ctrl_pkg.sv
// Shared types, widths and default field constants for the pong game controller.
package pong_pkg;
  localparam int X_W     = 8;
  localparam int Y_W     = 7;
  localparam int SCORE_W = 4;

  localparam int FIELD_W_DEF      = 160;
  localparam int FIELD_H_DEF      = 120;
  localparam int PADDLE_H_DEF     = 16;
  localparam int LPAD_X_DEF       = 2;
  localparam int RPAD_X_DEF       = 157;
  localparam int WIN_SCORE_DEF    = 7;
  localparam int SERVE_FRAMES_DEF = 60;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_POINT    = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_e;

  // Scores stick at the winning value instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                 input logic [SCORE_W-1:0] lim);
    return (s < lim) ? s + SCORE_W'(1) : s;
  endfunction
endpackage

// File: rtl/pong_ball_step.sv
// One-frame ball step: wall/paddle bounces and edge misses, purely combinational.
module pong_ball_step import pong_pkg::*; #(
  parameter int FIELD_W  = FIELD_W_DEF,
  parameter int FIELD_H  = FIELD_H_DEF,
  parameter int PADDLE_H = PADDLE_H_DEF,
  parameter int LPAD_X   = LPAD_X_DEF,
  parameter int RPAD_X   = RPAD_X_DEF
) (
  input  logic [X_W-1:0] i_x,
  input  logic [Y_W-1:0] i_y,
  input  logic           i_dx_neg,
  input  logic           i_dy_neg,
  input  logic [Y_W-1:0] i_pad_l_y,
  input  logic [Y_W-1:0] i_pad_r_y,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_dx_neg,
  output logic           o_dy_neg,
  output logic           o_miss_l,
  output logic           o_miss_r
);
  localparam logic [X_W-1:0] X_MAX    = X_W'(FIELD_W - 1);
  localparam logic [X_W-1:0] X_LHIT   = X_W'(LPAD_X + 1);
  localparam logic [X_W-1:0] X_RHIT   = X_W'(RPAD_X - 1);
  localparam logic [Y_W-1:0] Y_MAX    = Y_W'(FIELD_H - 1);
  localparam logic [Y_W:0]   PAD_SPAN = (Y_W+1)'(PADDLE_H - 1);

  // One extra bit so pad_y + PADDLE_H - 1 never wraps near the bottom.
  logic [Y_W:0] w_y8, w_pl8, w_pr8;
  logic         w_in_l, w_in_r, w_hit_l, w_hit_r, w_wall;

  assign w_y8  = {1'b0, i_y};
  assign w_pl8 = {1'b0, i_pad_l_y};
  assign w_pr8 = {1'b0, i_pad_r_y};

  assign w_in_l = (w_y8 >= w_pl8) && (w_y8 <= w_pl8 + PAD_SPAN);
  assign w_in_r = (w_y8 >= w_pr8) && (w_y8 <= w_pr8 + PAD_SPAN);

  assign w_wall   = i_dy_neg ? (i_y == '0) : (i_y == Y_MAX);
  assign o_dy_neg = i_dy_neg ^ w_wall;
  assign o_y      = o_dy_neg ? i_y - Y_W'(1) : i_y + Y_W'(1);

  assign w_hit_l  =  i_dx_neg && (i_x == X_LHIT) && w_in_l;
  assign w_hit_r  = !i_dx_neg && (i_x == X_RHIT) && w_in_r;
  assign o_miss_l =  i_dx_neg && (i_x == '0);
  assign o_miss_r = !i_dx_neg && (i_x == X_MAX);

  assign o_dx_neg = w_hit_l ? 1'b0 : (w_hit_r ? 1'b1 : i_dx_neg);
  assign o_x      = (o_miss_l || o_miss_r) ? i_x
                  : (o_dx_neg ? i_x - X_W'(1) : i_x + X_W'(1));
endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-level pong sequencer: ball, scoring and serve/play/game-over FSM.
// Optional PONG_AI_RIGHT_EN replaces the right paddle input with an internal tracker.
module pong_game_ctrl import pong_pkg::*; #(
  parameter int FIELD_W      = FIELD_W_DEF,
  parameter int FIELD_H      = FIELD_H_DEF,
  parameter int PADDLE_H     = PADDLE_H_DEF,
  parameter int LPAD_X       = LPAD_X_DEF,
  parameter int RPAD_X       = RPAD_X_DEF,
  parameter int WIN_SCORE    = WIN_SCORE_DEF,
  parameter int SERVE_FRAMES = SERVE_FRAMES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic [Y_W-1:0]     pad_l_y,
  input  logic [Y_W-1:0]     pad_r_y,
  output logic [X_W-1:0]     ball_x,
  output logic [Y_W-1:0]     ball_y,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [2:0]         game_state,
  output logic               game_over,
  output logic [Y_W-1:0]     pad_r_eff
);
  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [X_W-1:0]     CX       = X_W'(FIELD_W / 2);
  localparam logic [Y_W-1:0]     CY       = Y_W'(FIELD_H / 2);
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

  state_e             r_state, w_nxt_state;
  logic [X_W-1:0]     r_x, w_nxt_x, w_step_x;
  logic [Y_W-1:0]     r_y, w_nxt_y, w_step_y;
  logic               r_dx_neg, w_nxt_dx_neg, w_step_dx_neg;
  logic               r_dy_neg, w_nxt_dy_neg, w_step_dy_neg;
  logic [SCORE_W-1:0] r_score_l, w_nxt_score_l, r_score_r, w_nxt_score_r;
  logic [CNT_W-1:0]   r_cnt, w_nxt_cnt;
  logic               r_start_d, w_rise, w_miss_l, w_miss_r;
  logic [Y_W-1:0]     w_pad_r;

  assign w_rise = start_btn & ~r_start_d;

`ifdef PONG_AI_RIGHT_EN
  localparam logic [Y_W-1:0] AI_HALF = Y_W'(PADDLE_H / 2);
  localparam logic [Y_W-1:0] AI_MAX  = Y_W'(FIELD_H - PADDLE_H);
  logic [Y_W-1:0] r_pad_ai, w_ai_tgt;

  always_comb begin
    w_ai_tgt = (r_y < AI_HALF) ? '0 : r_y - AI_HALF;
    if (w_ai_tgt > AI_MAX) w_ai_tgt = AI_MAX;
  end

  // Tracker creeps one unit per frame toward the ball centre line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pad_ai <= Y_W'((FIELD_H - PADDLE_H) / 2);
    else if (ena && frame_tick && r_state == ST_PLAY) begin
      if (w_ai_tgt > r_pad_ai)      r_pad_ai <= r_pad_ai + Y_W'(1);
      else if (w_ai_tgt < r_pad_ai) r_pad_ai <= r_pad_ai - Y_W'(1);
    end
  end

  assign w_pad_r = r_pad_ai;
`else
  assign w_pad_r = pad_r_y;
`endif

  pong_ball_step #(
    .FIELD_W (FIELD_W),
    .FIELD_H (FIELD_H),
    .PADDLE_H(PADDLE_H),
    .LPAD_X  (LPAD_X),
    .RPAD_X  (RPAD_X)
  ) u_step (
    .i_x      (r_x),
    .i_y      (r_y),
    .i_dx_neg (r_dx_neg),
    .i_dy_neg (r_dy_neg),
    .i_pad_l_y(pad_l_y),
    .i_pad_r_y(w_pad_r),
    .o_x      (w_step_x),
    .o_y      (w_step_y),
    .o_dx_neg (w_step_dx_neg),
    .o_dy_neg (w_step_dy_neg),
    .o_miss_l (w_miss_l),
    .o_miss_r (w_miss_r)
  );

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_x       = r_x;
    w_nxt_y       = r_y;
    w_nxt_dx_neg  = r_dx_neg;
    w_nxt_dy_neg  = r_dy_neg;
    w_nxt_score_l = r_score_l;
    w_nxt_score_r = r_score_r;
    w_nxt_cnt     = r_cnt;
    case (r_state)
      ST_IDLE: if (w_rise) begin
        w_nxt_state  = ST_SERVE;
        w_nxt_cnt    = '0;
        w_nxt_dx_neg = 1'b0;
        w_nxt_x      = CX;
        w_nxt_y      = CY;
      end
      ST_SERVE: begin
        w_nxt_x = CX;
        w_nxt_y = CY;
        if (frame_tick) begin
          if (r_cnt == CNT_LAST) w_nxt_state = ST_PLAY;
          else                   w_nxt_cnt   = r_cnt + CNT_W'(1);
        end
      end
      ST_PLAY: if (frame_tick) begin
        w_nxt_x      = w_step_x;
        w_nxt_y      = w_step_y;
        w_nxt_dx_neg = w_step_dx_neg;
        w_nxt_dy_neg = w_step_dy_neg;
        // dx is left pointing at the loser, which is the next serve direction.
        if (w_miss_l) begin
          w_nxt_score_r = sat_inc(r_score_r, WIN);
          w_nxt_state   = ST_POINT;
        end else if (w_miss_r) begin
          w_nxt_score_l = sat_inc(r_score_l, WIN);
          w_nxt_state   = ST_POINT;
        end
      end
      ST_POINT: begin
        if (r_score_l == WIN || r_score_r == WIN) begin
          w_nxt_state = ST_GAMEOVER;
        end else begin
          w_nxt_state = ST_SERVE;
          w_nxt_cnt   = '0;
          w_nxt_x     = CX;
          w_nxt_y     = CY;
        end
      end
      ST_GAMEOVER: if (w_rise) begin
        w_nxt_state   = ST_SERVE;
        w_nxt_cnt     = '0;
        w_nxt_dx_neg  = 1'b0;
        w_nxt_score_l = '0;
        w_nxt_score_r = '0;
        w_nxt_x       = CX;
        w_nxt_y       = CY;
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_x       <= CX;
      r_y       <= CY;
      r_dx_neg  <= 1'b0;
      r_dy_neg  <= 1'b0;
      r_score_l <= '0;
      r_score_r <= '0;
      r_cnt     <= '0;
      r_start_d <= 1'b0;
    end else if (ena) begin
      r_state   <= w_nxt_state;
      r_x       <= w_nxt_x;
      r_y       <= w_nxt_y;
      r_dx_neg  <= w_nxt_dx_neg;
      r_dy_neg  <= w_nxt_dy_neg;
      r_score_l <= w_nxt_score_l;
      r_score_r <= w_nxt_score_r;
      r_cnt     <= w_nxt_cnt;
      r_start_d <= start_btn;
    end
  end

  assign ball_x     = r_x;
  assign ball_y     = r_y;
  assign score_l    = r_score_l;
  assign score_r    = r_score_r;
  assign game_state = r_state;
  assign game_over  = (r_state == ST_GAMEOVER);
  assign pad_r_eff  = w_pad_r;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed rally script, per-cycle model compare, literal pins.
module tb_pong_game_ctrl;
  localparam int SF = 4;
  localparam int FW = 160, FH = 120, PH = 16, WIN = 7;
  localparam int LX = 2, RX = 157;

  logic       clk = 1'b0, rst_n = 1'b1, ena = 1'b1, frame_tick = 1'b0, start_btn = 1'b0;
  logic [6:0] pad_l_y = 7'd40, pad_r_y = 7'd95;
  logic [7:0] ball_x;
  logic [6:0] ball_y, pad_r_eff;
  logic [3:0] score_l, score_r;
  logic [2:0] game_state;
  logic       game_over;

  int n_chk = 0, n_fail = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  pong_game_ctrl #(.SERVE_FRAMES(SF)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .frame_tick(frame_tick), .start_btn(start_btn),
    .pad_l_y(pad_l_y), .pad_r_y(pad_r_y), .ball_x(ball_x), .ball_y(ball_y),
    .score_l(score_l), .score_r(score_r), .game_state(game_state),
    .game_over(game_over), .pad_r_eff(pad_r_eff)
  );

  // Game model: states 0 idle, 1 serve, 2 play, 3 point, 4 game over; dx/dy are +1/-1.
  typedef struct {
    int st; int x; int y; int dx; int dy; int sl; int sr; int cnt; int pad; bit prev;
  } m_t;

  m_t m;

  function automatic m_t m_reset();
    m_t r;
    r.st = 0; r.x = FW / 2; r.y = FH / 2; r.dx = 1; r.dy = 1;
    r.sl = 0; r.sr = 0; r.cnt = 0; r.pad = (FH - PH) / 2; r.prev = 1'b0;
    return r;
  endfunction

  function automatic m_t m_step(m_t s, bit en, bit tk, bit sb, int pl, int pr);
    m_t n = s;
    bit rise;
    int pe, tgt;
    if (!en) return s;
    rise = sb && !s.prev;
    n.prev = sb;
`ifdef PONG_AI_RIGHT_EN
    pe = s.pad;
`else
    pe = pr;
`endif
    case (s.st)
      0: if (rise) begin n.st = 1; n.cnt = 0; n.dx = 1; n.x = FW / 2; n.y = FH / 2; end
      1: if (tk) begin
        if (s.cnt == SF - 1) n.st = 2; else n.cnt = s.cnt + 1;
      end
      2: if (tk) begin
        if (s.y + s.dy < 0 || s.y + s.dy > FH - 1) n.dy = -s.dy;
        n.y = s.y + n.dy;
        if (s.x + s.dx < 0) begin
          n.sr = (s.sr < WIN) ? s.sr + 1 : s.sr; n.st = 3;
        end else if (s.x + s.dx > FW - 1) begin
          n.sl = (s.sl < WIN) ? s.sl + 1 : s.sl; n.st = 3;
        end else if (s.dx < 0 && s.x == LX + 1 && s.y >= pl && s.y <= pl + PH - 1) begin
          n.dx = 1; n.x = s.x + 1;
        end else if (s.dx > 0 && s.x == RX - 1 && s.y >= pe && s.y <= pe + PH - 1) begin
          n.dx = -1; n.x = s.x - 1;
        end else begin
          n.x = s.x + s.dx;
        end
`ifdef PONG_AI_RIGHT_EN
        tgt = s.y - PH / 2;
        if (tgt < 0) tgt = 0;
        if (tgt > FH - PH) tgt = FH - PH;
        if (tgt > s.pad) n.pad = s.pad + 1; else if (tgt < s.pad) n.pad = s.pad - 1;
`else
        tgt = 0;
`endif
      end
      3: if (s.sl == WIN || s.sr == WIN) n.st = 4;
         else begin n.st = 1; n.cnt = 0; n.x = FW / 2; n.y = FH / 2; end
      4: if (rise) begin
        n.st = 1; n.cnt = 0; n.dx = 1; n.sl = 0; n.sr = 0; n.x = FW / 2; n.y = FH / 2;
      end
      default: n.st = 0;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= m_reset();
    else        m <= m_step(m, ena, frame_tick, start_btn, int'(pad_l_y), int'(pad_r_y));
  end

  initial forever begin
    int exp_pad;
    @(negedge clk);
    if (cmp_en) begin
`ifdef PONG_AI_RIGHT_EN
      exp_pad = m.pad;
`else
      exp_pad = int'(pad_r_y);
`endif
      n_chk++;
      if (int'(ball_x) != m.x || int'(ball_y) != m.y || int'(score_l) != m.sl ||
          int'(score_r) != m.sr || int'(game_state) != m.st ||
          game_over != (m.st == 4) || int'(pad_r_eff) != exp_pad) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t dut x=%0d y=%0d sl=%0d sr=%0d st=%0d go=%0d pad=%0d model x=%0d y=%0d sl=%0d sr=%0d st=%0d pad=%0d",
                 $time, ball_x, ball_y, score_l, score_r, game_state, game_over, pad_r_eff,
                 m.x, m.y, m.sl, m.sr, m.st, exp_pad);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
  endtask

  task automatic press();
    start_btn = 1'b1;
    @(posedge clk); #1;
    start_btn = 1'b0;
  endtask

  // mode 0 keeps the paddle on the ball, mode 1 keeps it well clear.
  function automatic logic [6:0] pad_for(input int mode, input int y);
    if (mode == 0) return 7'((y >= PH / 2) ? y - PH / 2 : 0);
    return 7'((y < FH / 2) ? 100 : 0);
  endfunction

  task automatic run_point(input int lm, input int rm);
    int k;
    for (k = 0; k < 600; k++) begin
      pad_l_y = pad_for(lm, m.y);
      pad_r_y = pad_for(rm, m.y);
      tick();
      if (game_state == 3'd3) break;
    end
    n_chk++;
    if (k >= 600) begin
      n_fail++;
      $display("FAIL point_timeout got=no_point exp=point_within_600_ticks");
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;

    chk("rst_x", ball_x, 80);
    chk("rst_y", ball_y, 60);
    chk("rst_state", game_state, 0);
    chk("rst_scores", {score_l, score_r}, 0);
    chk("rst_go", game_over, 0);
`ifdef PONG_AI_RIGHT_EN
    chk("ai_pad_rst", pad_r_eff, 52);
`else
    pad_r_y = 7'd33; #1;
    chk("pad_passthru", pad_r_eff, 33);
    pad_r_y = 7'd95;
`endif

    press();
    chk("serve_entry", game_state, 1);
    repeat (3) tick();
    chk("serve_hold_st", game_state, 1);
    chk("serve_hold_x", ball_x, 80);
    tick();
    chk("play_entry_st", game_state, 2);
    chk("play_entry_xy", {ball_x, 1'b0, ball_y}, {8'd80, 8'd60});
    tick();
    chk("first_step_xy", {ball_x, 1'b0, ball_y}, {8'd81, 8'd61});
    repeat (59) tick();
    chk("wall_bottom_xy", {ball_x, 1'b0, ball_y}, {8'd140, 8'd118});
`ifndef PONG_AI_RIGHT_EN
    repeat (17) tick();
    chk("rpad_hit_xy", {ball_x, 1'b0, ball_y}, {8'd155, 8'd101});
    repeat (102) tick();
    chk("wall_top_xy", {ball_x, 1'b0, ball_y}, {8'd53, 8'd1});
    repeat (51) tick();
    chk("lpad_hit_xy", {ball_x, 1'b0, ball_y}, {8'd4, 8'd52});
`endif

    run_point(1, 0);
    chk("lmiss_score_r", score_r, 1);
    chk("lmiss_point_st", game_state, 3);
    @(posedge clk); #1;
    chk("point_to_serve", game_state, 1);
    chk("recentre_x", ball_x, 80);
    repeat (5) tick();
    chk("serve_to_loser_x", ball_x, 79);

    for (int i = 0; i < 7; i++) begin
      if (i == 6) chk("pre_win_score_l", score_l, 6);
      run_point(0, 1);
      chk("score_l_inc", score_l, i + 1);
      @(posedge clk); #1;
    end
    chk("gameover_st", game_state, 4);
    chk("gameover_flag", game_over, 1);
    chk("gameover_sr", score_r, 1);
    repeat (5) tick();
    chk("gameover_frozen_st", game_state, 4);
    chk("gameover_frozen_sl", score_l, 7);

    press();
    chk("restart_scores", {score_l, score_r}, 0);
    chk("restart_st", game_state, 1);
    pad_l_y = 7'd40; pad_r_y = 7'd95;
    repeat (4) tick();
    repeat (5) tick();
    chk("restart_play_x", ball_x, 85);
    ena = 1'b0;
    repeat (10) tick();
    chk("ena_freeze_x", ball_x, 85);
    chk("ena_freeze_st", game_state, 2);
    ena = 1'b1;
    repeat (2) tick();
    chk("ena_resume_x", ball_x, 87);

    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_x", ball_x, 80);
    chk("async_rst_y", ball_y, 60);
    chk("async_rst_st", game_state, 0);
    chk("async_rst_sc", {score_l, score_r}, 0);
    chk("async_rst_go", game_over, 0);
    #20 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
